// File: rtl/fll_cfg_arbiter.sv
// fll_cfg_arbiter: round-robin arbiter that sequences two requesters onto the
// single FLL configuration port with a 4-phase req/ack handshake and timeout.
module fll_cfg_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 req_i,
  input  logic [1:0]                 wrn_i,
  input  logic [1:0][1:0]            add_i,
  input  logic [1:0][DATA_WIDTH-1:0] wdata_i,
  output logic [1:0]                 ack_o,
  output logic [1:0]                 err_o,
  output logic [DATA_WIDTH-1:0]      rdata_o,
  output logic                       fll_req_o,
  output logic                       fll_wrn_o,
  output logic [1:0]                 fll_add_o,
  output logic [DATA_WIDTH-1:0]      fll_wdata_o,
  input  logic                       fll_ack_i,
  input  logic [DATA_WIDTH-1:0]      fll_rdata_i,
  output logic                       busy_o
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, REQ, REL, DONE} state_t;
  state_t state, state_nxt;
  logic g, last, err_q, gnt, grant, tmo, err_set;
  logic [CW-1:0] cnt;
  assign grant = (state == IDLE || state == DONE) && |req_i;
  assign gnt = &req_i ? ~last : req_i[1];
  // cnt counts completed REQ/REL cycles, so this is the cycle it reaches TIMEOUT
  assign tmo = TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1);
  assign err_set = tmo && ((state == REQ && !fll_ack_i) || (state == REL && fll_ack_i));
  assign fll_req_o = state == REQ;
  assign busy_o = state != IDLE;
  assign ack_o = state == DONE ? {g, ~g} : 2'b00;
  assign err_o = ack_o & {2{err_q}};
  always_comb begin
    state_nxt = state;
    case (state)
      REQ:     state_nxt = fll_ack_i ? REL : tmo ? DONE : REQ;
      REL:     state_nxt = !fll_ack_i || tmo ? DONE : REL;
      default: state_nxt = |req_i ? REQ : IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      g           <= 1'b0;
      last        <= 1'b1;
      err_q       <= 1'b0;
      cnt         <= '0;
      rdata_o     <= '0;
      fll_wrn_o   <= 1'b0;
      fll_add_o   <= '0;
      fll_wdata_o <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= grant ? '0 : (state == REQ || state == REL) ? cnt + 1'b1 : cnt;
      err_q <= grant ? 1'b0 : err_set ? 1'b1 : err_q;
      if (grant) begin
        g           <= gnt;
        last        <= gnt;
        fll_wrn_o   <= wrn_i[gnt];
        fll_add_o   <= add_i[gnt];
        fll_wdata_o <= wdata_i[gnt];
      end
      if (state == REQ && fll_ack_i && fll_wrn_o) rdata_o <= fll_rdata_i;
    end
  end
endmodule
